act_stream_unpacker: RTL and testbench

- Inverse of the PE-array output packing path. Accepts packed activation words at 8-, 4- or 2-bit precision, in either the lane-wise (CNN) or the interleaved (FC/EWS) layout.
- Emits one full-width, sign-extended activation vector per sub-beat.
- Sits between the activation memory read port and the input buffer's parallel or serial load, so packed outputs from a previous layer can be consumed as inputs to the next.
- Uses valid/ready on both sides and contains a single holding register.

---
 rtl/act_stream_unpacker.sv | 133 +++++++++++++
 tb/tb_act_stream_unpacker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/act_stream_unpacker.sv
// Activation stream unpacker: splits packed 8/4/2-bit activation words into
// sign-extended full-width vectors, one per sub-beat, behind valid/ready handshakes.
module act_stream_unpacker #(
    parameter int         N_DIM_ARRAY    = 8,
    parameter int         ACT_DATA_WIDTH = 8,
    parameter logic [2:0] MODE_CNN       = 3'd0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  clear,
    input  logic [1:0]                            precision,
    input  logic [2:0]                            mode,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] out_data,
    output logic                                  out_last
);

    localparam int DW    = N_DIM_ARRAY * ACT_DATA_WIDTH;
    localparam int IDX_W = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t          state, next_state;
    logic [1:0]      k, next_k;
    logic            load;
    logic [DW-1:0]   word_q;
    logic [1:0]      prec_q;
    logic [2:0]      mode_q;
    logic [1:0]      sb_m1;
    logic            in_hs;
    logic [DW-1:0]   unpacked;

    // Sub-beats per word minus one, from the precision latched with the word.
    always_comb begin
        case (prec_q)
            2'd1:    sb_m1 = 2'd1;
            2'd2:    sb_m1 = 2'd3;
            default: sb_m1 = 2'd0;
        endcase
    end

    assign in_ready  = !reset && !clear &&
                       ((state == EMPTY) || (out_ready && (k == sb_m1)));
    assign in_hs     = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign out_last  = (state == HOLD) && (k == sb_m1);
    assign out_data  = unpacked;

    always_comb begin
        next_state = state;
        next_k     = k;
        load       = 1'b0;
        if (state == EMPTY) begin
            if (in_hs) begin
                next_state = HOLD;
                next_k     = 2'd0;
                load       = 1'b1;
            end
        end else begin
            if (out_ready) begin
                if (k == sb_m1) begin
                    next_k = 2'd0;
                    if (in_hs) begin
                        load = 1'b1;
                    end else begin
                        next_state = EMPTY;
                    end
                end else begin
                    next_k = k + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            k      <= 2'd0;
            word_q <= '0;
            prec_q <= 2'd0;
            mode_q <= 3'd0;
        end else if (clear) begin
            state <= EMPTY;
            k     <= 2'd0;
        end else begin
            state <= next_state;
            k     <= next_k;
            if (load) begin
                word_q <= in_data;
                prec_q <= precision;
                mode_q <= mode;
            end
        end
    end

    // Output vector is decoded from the holding register only; the sub-word
    // width is lane width >> lg, where 2**lg is the sub-beat count.
    always_comb begin
        int lg;
        int sw;
        int src;
        int sub;
        int bit_idx;
        unpacked = '0;
        case (sb_m1)
            2'd1:    lg = 1;
            2'd3:    lg = 2;
            default: lg = 0;
        endcase
        sw = ACT_DATA_WIDTH >> lg;
        for (int e = 0; e < N_DIM_ARRAY; e++) begin
            if (mode_q == MODE_CNN) begin
                src = e;
                sub = int'(k);
            end else begin
                src = int'(k) * (N_DIM_ARRAY >> lg) + (e >> lg);
                sub = e & ((1 << lg) - 1);
            end
            for (int b = 0; b < ACT_DATA_WIDTH; b++) begin
                bit_idx = src * ACT_DATA_WIDTH + sub * sw + ((b < sw) ? b : sw - 1);
                unpacked[IDX_W'(e * ACT_DATA_WIDTH + b)] = word_q[IDX_W'(bit_idx)];
            end
        end
    end

endmodule

// File: tb/tb_act_stream_unpacker.sv
// Directed bench for act_stream_unpacker: pass-through, CNN/FC sub-word unpacking,
// backpressure, back-to-back words, clear and reset mid-word.
module tb_act_stream_unpacker;

    localparam int         N  = 8;
    localparam int         W  = 8;
    localparam logic [2:0] MODE_CNN = 3'd0;
    localparam logic [2:0] MODE_FC  = 3'd1;

    logic          clk = 1'b0;
    logic          reset, clear, in_valid, out_ready;
    logic [1:0]    precision;
    logic [2:0]    mode;
    logic [N*W-1:0] in_data;
    logic          in_ready, out_valid, out_last;
    logic [N*W-1:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    act_stream_unpacker #(.N_DIM_ARRAY(N), .ACT_DATA_WIDTH(W), .MODE_CNN(MODE_CNN)) dut (
        .clk(clk), .reset(reset), .clear(clear), .precision(precision), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic l, input logic [63:0] d);
        check_val({tag, "_valid"}, 64'(out_valid), 64'(v));
        check_val({tag, "_last"},  64'(out_last),  64'(l));
        check_val({tag, "_data"},  out_data,       d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] exp_b2b [8];

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        precision = 2'd0; mode = MODE_CNN; in_data = '0;
        step(); step();
        check_val("rst_ready", 64'(in_ready), 64'd0);
        expect_out("rst", 1'b0, 1'b0, 64'd0);
        reset = 1'b0;
        #1 check_val("ready_after_rst", 64'(in_ready), 64'd1);

        // pass-through, one word per cycle
        precision = 2'd0; mode = MODE_CNN; in_data = 64'h00000000_FF01807F;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        expect_out("t1_w0", 1'b1, 1'b1, 64'h00000000_FF01807F);
        in_data = 64'h11223344_55667788;
        #1 check_val("t1_ready", 64'(in_ready), 64'd1);
        step();
        expect_out("t1_w1", 1'b1, 1'b1, 64'h11223344_55667788);
        in_valid = 1'b0;
        step();
        check_val("t1_idle", 64'(out_valid), 64'd0);

        // CNN 4-bit
        precision = 2'd1; mode = MODE_CNN; in_data = 64'h7A7A7A7A_7A7A7A7A; in_valid = 1'b1;
        #1 check_val("t2_ready_empty", 64'(in_ready), 64'd1);
        step();
        expect_out("t2_sb0", 1'b1, 1'b0, 64'hFAFAFAFA_FAFAFAFA);
        in_valid = 1'b0;
        #1 check_val("t2_ready_sb0", 64'(in_ready), 64'd0);
        step();
        expect_out("t2_sb1", 1'b1, 1'b1, 64'h07070707_07070707);
        step();
        check_val("t2_idle", 64'(out_valid), 64'd0);

        // FC 2-bit
        precision = 2'd2; mode = MODE_FC; in_data = 64'hE4E4E4E4_E4E4E4E4; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("t3_sb%0d", i), 1'b1, (i == 3), 64'hFFFE0100_FFFE0100);
            step();
        end
        check_val("t3_idle", 64'(out_valid), 64'd0);

        // FC 4-bit with distinct lanes (checks source lane order)
        precision = 2'd1; mode = MODE_FC; in_data = 64'h87654321_FEDCBA98; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        expect_out("t3b_sb0", 1'b1, 1'b0, 64'hFFFEFDFC_FBFAF9F8);
        step();
        expect_out("t3b_sb1", 1'b1, 1'b1, 64'hF8070605_04030201);
        step();
        check_val("t3b_idle", 64'(out_valid), 64'd0);

        // backpressure on a 4-bit word; late precision/mode changes must not matter
        precision = 2'd1; mode = MODE_CNN; in_data = 64'h7A7A7A7A_7A7A7A7A;
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0; precision = 2'd2; mode = MODE_FC;
        for (int i = 0; i < 5; i++) begin
            expect_out($sformatf("t4_stall%0d", i), 1'b1, 1'b0, 64'hFAFAFAFA_FAFAFAFA);
            check_val($sformatf("t4_ready%0d", i), 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        expect_out("t4_sb1", 1'b1, 1'b1, 64'h07070707_07070707);
        step();
        check_val("t4_idle", 64'(out_valid), 64'd0);

        // back-to-back 2-bit words: FC then CNN
        exp_b2b[0] = 64'hFFFE0100_FFFE0100; exp_b2b[1] = 64'hFFFE0100_FFFE0100;
        exp_b2b[2] = 64'hFFFE0100_FFFE0100; exp_b2b[3] = 64'hFFFE0100_FFFE0100;
        exp_b2b[4] = 64'h00000000_00000000; exp_b2b[5] = 64'h01010101_01010101;
        exp_b2b[6] = 64'hFEFEFEFE_FEFEFEFE; exp_b2b[7] = 64'hFFFFFFFF_FFFFFFFF;
        precision = 2'd2; mode = MODE_FC; in_data = 64'hE4E4E4E4_E4E4E4E4;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        mode = MODE_CNN;
        for (int v = 0; v < 8; v++) begin
            expect_out($sformatf("t5_v%0d", v), 1'b1, ((v % 4) == 3), exp_b2b[v]);
            if (v == 1) check_val("t5_ready_mid", 64'(in_ready), 64'd0);
            if (v == 3) check_val("t5_ready_last", 64'(in_ready), 64'd1);
            if (v == 4) in_valid = 1'b0;
            step();
        end
        check_val("t5_idle", 64'(out_valid), 64'd0);

        // clear after sub-beat 0
        precision = 2'd1; mode = MODE_CNN; in_data = 64'h7A7A7A7A_7A7A7A7A; in_valid = 1'b1;
        step();
        expect_out("t6_sb0", 1'b1, 1'b0, 64'hFAFAFAFA_FAFAFAFA);
        clear = 1'b1;
        #1 check_val("t6_ready_clr_hold", 64'(in_ready), 64'd0);
        step();
        check_val("t6_valid_clr", 64'(out_valid), 64'd0);
        check_val("t6_ready_clr_empty", 64'(in_ready), 64'd0);
        clear = 1'b0; in_valid = 1'b0;
        step();
        check_val("t6_no_sb1_valid", 64'(out_valid), 64'd0);
        check_val("t6_no_sb1_last", 64'(out_last), 64'd0);

        // reset during HOLD
        precision = 2'd2; mode = MODE_FC; in_data = 64'hE4E4E4E4_E4E4E4E4; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        expect_out("t7_sb0", 1'b1, 1'b0, 64'hFFFE0100_FFFE0100);
        reset = 1'b1;
        #1 check_val("t7_ready_rst", 64'(in_ready), 64'd0);
        step();
        expect_out("t7_rst", 1'b0, 1'b0, 64'd0);
        reset = 1'b0;
        #1 check_val("t7_ready_after", 64'(in_ready), 64'd1);
        step();
        check_val("t7_idle", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
